tm_sequencer: RTL and testbench

TM_SEQUENCER -- requirements
Module: tm_sequencer

---
 rtl/tm_pkg.sv | 39 +++
 rtl/tm_sequencer_if.sv | 26 ++
 rtl/tm_decode.sv | 23 ++
 rtl/tm_sequencer.sv | 130 +++++++++++++
 tb/tb_tm_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tm_pkg.sv
// Shared definitions for the Turing-machine sequencer: program-word field
// positions, sequencer states, halt-cause codes and the decoded half-word.
package tm_pkg;

    localparam int LABEL_W = 6;
    localparam int WORD_W  = 16;
    localparam int POS_W   = 8;
    localparam int STEP_W  = 16;

    // Bit-0 half occupies [15:8], bit-1 half occupies [7:0]
    localparam int TOG0_BIT  = 15;
    localparam int MOVE0_BIT = 14;
    localparam int NEXT0_LO  = 8;
    localparam int TOG1_BIT  = 7;
    localparam int MOVE1_BIT = 6;
    localparam int NEXT1_LO  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MOVE,
        ST_HALT
    } tm_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_GOTO_ZERO  = 2'b01,
        CAUSE_OOB        = 2'b10,
        CAUSE_STEP_LIMIT = 2'b11
    } halt_cause_e;

    typedef struct packed {
        logic               toggle;
        logic               move_right;
        logic [LABEL_W-1:0] next;
    } half_word_t;

endpackage

// File: rtl/tm_sequencer_if.sv
// Bundle between the sequencer (master) and its program page / tape track (slave).
interface tm_sequencer_if;
    import tm_pkg::*;

    logic               start;
    logic [LABEL_W-1:0] instr_addr;
    logic [WORD_W-1:0]  instr_data;
    logic               cell_state;
    logic [POS_W-1:0]   position;
    logic               write_flag;
    logic               busy;
    logic               halted;
    logic [1:0]         halt_cause;
    logic [STEP_W-1:0]  step_count;

    modport master (
        input  start, instr_data, cell_state,
        output instr_addr, position, write_flag, busy, halted, halt_cause, step_count
    );

    modport slave (
        output start, instr_data, cell_state,
        input  instr_addr, position, write_flag, busy, halted, halt_cause, step_count
    );

endinterface

// File: rtl/tm_decode.sv
// Combinational half-word selector: the tape bit picks which half of the
// program word supplies toggle, move direction and next label.
module tm_decode
    import tm_pkg::*;
(
    input  logic              cell_state,
    input  logic [WORD_W-1:0] word,
    output half_word_t        sel
);

    logic [LABEL_W-1:0] next_sel;

    for (genvar gi = 0; gi < LABEL_W; gi++) begin : g_next
        assign next_sel[gi] = cell_state ? word[NEXT1_LO + gi] : word[NEXT0_LO + gi];
    end

    assign sel = '{
        toggle:     cell_state ? word[TOG1_BIT]  : word[TOG0_BIT],
        move_right: cell_state ? word[MOVE1_BIT] : word[MOVE0_BIT],
        next:       next_sel
    };

endmodule

// File: rtl/tm_sequencer.sv
// Turing-machine sequencer: FETCH/EXEC/MOVE step loop over an external program
// page and tape track. Defining STEP_LIMIT_EN adds a halt after MAX_STEPS steps.
module tm_sequencer
    import tm_pkg::*;
#(
    parameter int TRACK_LENGTH = 64,
    parameter int START_POS    = 1,
    parameter int START_STATE  = 1,
    parameter int MAX_STEPS    = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    tm_sequencer_if.master bus
);

    localparam logic [POS_W-1:0]   RESET_POS   = POS_W'(START_POS);
    localparam logic [POS_W-1:0]   LAST_POS    = POS_W'(TRACK_LENGTH - 1);
    localparam logic [LABEL_W-1:0] RESET_LABEL = LABEL_W'(START_STATE);
    localparam logic [31:0]        STEP_LIMIT  = 32'(MAX_STEPS);
`ifdef STEP_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    tm_state_e          state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [LABEL_W-1:0] label_q, label_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    halt_cause_e        cause_q, cause_d;
    logic               move_q, move_d;
    logic [LABEL_W-1:0] next_q, next_d;

    half_word_t         sel;
    logic               toggle_req;
    logic [STEP_W-1:0]  steps_inc;
    logic               oob;
    logic               limit_hit;

    tm_decode u_decode (
        .cell_state (bus.cell_state),
        .word       (bus.instr_data),
        .sel        (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pos_q   <= RESET_POS;
            label_q <= RESET_LABEL;
            steps_q <= '0;
            cause_q <= CAUSE_NONE;
            move_q  <= 1'b0;
            next_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            label_q <= label_d;
            steps_q <= steps_d;
            cause_q <= cause_d;
            move_q  <= move_d;
            next_q  <= next_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        label_d    = label_q;
        steps_d    = steps_q;
        cause_d    = cause_q;
        move_d     = move_q;
        next_d     = next_q;
        toggle_req = 1'b0;

        steps_inc = (steps_q == '1) ? steps_q : steps_q + 1'b1;
        oob       = move_q ? (pos_q == LAST_POS) : (pos_q == '0);
        limit_hit = LIMIT_EN && ({16'd0, steps_inc} >= STEP_LIMIT);

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    pos_d   = RESET_POS;
                    label_d = RESET_LABEL;
                    steps_d = '0;
                    cause_d = CAUSE_NONE;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                // Decoded fields are latched so a toggle landing on the tape
                // this cycle cannot change the move/next used in MOVE.
                toggle_req = sel.toggle;
                move_d     = sel.move_right;
                next_d     = sel.next;
                state_d    = ST_MOVE;
            end
            ST_MOVE: begin
                steps_d = steps_inc;
                label_d = next_q;
                if (oob) begin
                    cause_d = CAUSE_OOB;
                    state_d = ST_HALT;
                end else begin
                    pos_d = move_q ? pos_q + 1'b1 : pos_q - 1'b1;
                    if (next_q == '0) begin
                        cause_d = CAUSE_GOTO_ZERO;
                        state_d = ST_HALT;
                    end else if (limit_hit) begin
                        cause_d = CAUSE_STEP_LIMIT;
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.instr_addr = label_q;
    assign bus.position   = pos_q;
    assign bus.write_flag = toggle_req;
    assign bus.busy       = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_MOVE);
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.halt_cause = cause_q;
    assign bus.step_count = steps_q;

endmodule

// File: tb/tb_tm_sequencer.sv
// Bench for tm_sequencer: three instances (START_POS 1/0/10, MAX_STEPS 256/256/4)
// checked every cycle against a step-level model, plus literal end-of-run values.
module tb_tm_sequencer;
    import tm_pkg::*;

    localparam int NI = 3;
`ifdef STEP_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    function automatic int sp_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 10;
        endcase
    endfunction

    function automatic int ms_of(input int i);
        return (i == 2) ? 4 : 256;
    endfunction

    typedef struct packed {
        logic        busy;
        logic        halted;
        logic [1:0]  cause;
        logic [7:0]  pos;
        logic [5:0]  addr;
        logic [15:0] steps;
        logic        wf;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tape_load;
    logic        start_v   [NI];
    logic [15:0] prog      [NI][64];
    logic        tape      [NI][64];
    logic        tape_init [NI][64];
    logic [15:0] idata     [NI];
    int          wf_cnt    [NI];

    logic [5:0]  addr_w  [NI];
    logic [7:0]  pos_w   [NI];
    logic        wf_w    [NI];
    logic        busy_w  [NI];
    logic        halt_w  [NI];
    logic [1:0]  cause_w [NI];
    logic [15:0] steps_w [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        tm_sequencer_if ifc ();
        assign ifc.start      = start_v[gi];
        assign ifc.instr_data = idata[gi];
        assign ifc.cell_state = tape[gi][ifc.position[5:0]];
        assign addr_w[gi]     = ifc.instr_addr;
        assign pos_w[gi]      = ifc.position;
        assign wf_w[gi]       = ifc.write_flag;
        assign busy_w[gi]     = ifc.busy;
        assign halt_w[gi]     = ifc.halted;
        assign cause_w[gi]    = ifc.halt_cause;
        assign steps_w[gi]    = ifc.step_count;

        tm_sequencer #(
            .TRACK_LENGTH (64),
            .START_POS    (sp_of(gi)),
            .START_STATE  (1),
            .MAX_STEPS    (ms_of(gi))
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc.master)
        );
    end

    // Program page (registered read) and tape track for every instance
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            idata[i] <= prog[i][addr_w[i]];
            if (tape_load) begin
                for (int j = 0; j < 64; j++) tape[i][j] <= tape_init[i][j];
            end else if (wf_w[i]) begin
                tape[i][pos_w[i][5:0]] <= ~tape[i][pos_w[i][5:0]];
                wf_cnt[i] <= wf_cnt[i] + 1;
            end
        end
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   start_cyc = 0;
    bit   chk_on   = 1'b0;
    int   cur      = 0;
    obs_t trace[$];
    obs_t fin;
    logic mtape [64];

    function automatic obs_t observe(input int i);
        obs_t o;
        o.busy   = busy_w[i];
        o.halted = halt_w[i];
        o.cause  = cause_w[i];
        o.pos    = pos_w[i];
        o.addr   = addr_w[i];
        o.steps  = steps_w[i];
        o.wf     = wf_w[i];
        return o;
    endfunction

    function automatic obs_t mk(input logic b, input logic h, input int c, input int p,
                                input int a, input int s, input logic w);
        obs_t o;
        o.busy = b; o.halted = h; o.cause = 2'(c); o.pos = 8'(p);
        o.addr = 6'(a); o.steps = 16'(s); o.wf = w;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got busy=%0b halted=%0b cause=%0d pos=%0d addr=%0d steps=%0d wf=%0b, want busy=%0b halted=%0b cause=%0d pos=%0d addr=%0d steps=%0d wf=%0b",
                     name, act.busy, act.halted, act.cause, act.pos, act.addr, act.steps, act.wf,
                     exp_v.busy, exp_v.halted, exp_v.cause, exp_v.pos, exp_v.addr, exp_v.steps, exp_v.wf);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
        end
    endtask

    // Step-level model: every step is FETCH, EXEC (toggle shown), MOVE; the run
    // ends in a halted record holding the final position/label/count/cause.
    task automatic build_model(input int inst);
        int pos, lab, steps, cause;
        logic [15:0] word;
        logic [7:0]  half;
        bit oob;
        pos = sp_of(inst); lab = 1; steps = 0; cause = 0;
        trace.delete();
        for (int j = 0; j < 64; j++) mtape[j] = tape_init[inst][j];
        for (int n = 0; n < 1000 && cause == 0; n++) begin
            word = prog[inst][lab];
            half = mtape[pos] ? word[7:0] : word[15:8];
            trace.push_back(mk(1'b1, 1'b0, 0, pos, lab, steps, 1'b0));
            trace.push_back(mk(1'b1, 1'b0, 0, pos, lab, steps, half[7]));
            trace.push_back(mk(1'b1, 1'b0, 0, pos, lab, steps, 1'b0));
            if (half[7]) mtape[pos] = ~mtape[pos];
            if (steps < 65535) steps++;
            oob = (pos == 0 && !half[6]) || (pos == 63 && half[6]);
            if (!oob) pos = half[6] ? pos + 1 : pos - 1;
            lab = int'(half[5:0]);
            if (oob)                                 cause = 2;
            else if (lab == 0)                       cause = 1;
            else if (LIMIT_ON && steps >= ms_of(inst)) cause = 3;
        end
        fin = mk(1'b0, 1'b1, cause, pos, lab, steps, 1'b0);
    endtask

    task automatic compare_loop();
        obs_t exp_v;
        int   idx;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (chk_on) begin
                idx   = cyc - start_cyc - 1;
                exp_v = (idx < trace.size()) ? trace[idx] : fin;
                check_obs($sformatf("inst%0d_cyc%0d", cur, idx), observe(cur), exp_v);
            end
        end
    endtask

    task automatic reload_tape();
        @(negedge clk); tape_load = 1'b1;
        @(negedge clk); tape_load = 1'b0;
    endtask

    task automatic run(input int inst, input bit poke_busy, output int wf_delta);
        int base, len, mism;
        reload_tape();
        build_model(inst);
        base = wf_cnt[inst];
        len  = trace.size();
        cur = inst; start_cyc = cyc; chk_on = 1'b1;
        start_v[inst] = 1'b1;
        for (int k = 1; k <= len + 2; k++) begin
            @(negedge clk);
            start_v[inst] = poke_busy && (k == 4 || k == 8);
        end
        start_v[inst] = 1'b0;
        wf_delta = wf_cnt[inst] - base;
        mism = 0;
        for (int j = 0; j < 64; j++) if (tape[inst][j] !== mtape[j]) mism++;
        check_int($sformatf("inst%0d_tape_cells_differing", inst), mism, 0);
        $display("run inst%0d: %0d steps, cause %0d, pos %0d, toggles %0d",
                 inst, steps_w[inst], cause_w[inst], pos_w[inst], wf_delta);
    endtask

    initial begin
        int wfd, base;
        rst_n = 1'b0;
        tape_load = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0;
            for (int j = 0; j < 64; j++) begin
                prog[i][j]      = 16'h0000;
                tape_init[i][j] = 1'b0;
            end
        end
        fork
            compare_loop();
        join_none

        repeat (3) @(negedge clk);
        tape_load = 1'b0;
        for (int i = 0; i < NI; i++)
            check_obs($sformatf("reset_inst%0d", i), observe(i),
                      mk(1'b0, 1'b0, 0, sp_of(i), 1, 0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // A2A1: bit-0 half toggles, moves left, names line 34 (field 0x22);
        // line 34 = 4040 moves right into label 0 -> goto-zero after 2 steps.
        prog[0][1]  = 16'hA2A1;
        prog[0][2]  = 16'h0000;
        prog[0][34] = 16'h4040;
        run(0, 1'b0, wfd);
        check_obs("gz_final", observe(0), mk(1'b0, 1'b1, 1, 1, 0, 2, 1'b0));
        check_int("gz_toggles", wfd, 1);
        check_int("gz_tape1", int'(tape[0][1]), 1);

        // Head at 0 moving left: one toggle, position held, out-of-bounds
        prog[1][1] = 16'h8181;
        run(1, 1'b0, wfd);
        check_obs("oob_left_final", observe(1), mk(1'b0, 1'b1, 2, 0, 1, 1, 1'b0));
        check_int("oob_left_toggles", wfd, 1);

        // Right-walking self-loop from HALT, with start pokes while busy
        prog[0][1] = 16'h4141;
        run(0, 1'b1, wfd);
        check_obs("oob_right_final", observe(0), mk(1'b0, 1'b1, 2, 63, 1, 63, 1'b0));
        check_int("oob_right_toggles", wfd, 0);

        // Left-walking self-loop from 10 with a 4-step budget
        prog[2][1] = 16'h0101;
        run(2, 1'b0, wfd);
`ifdef STEP_LIMIT_EN
        check_obs("limit_final", observe(2), mk(1'b0, 1'b1, 3, 6, 1, 4, 1'b0));
`else
        check_obs("limit_final", observe(2), mk(1'b0, 1'b1, 2, 0, 1, 11, 1'b0));
`endif

        // Reset asserted while EXEC drives a toggle
        chk_on = 1'b0;
        prog[0][1] = 16'h8181;
        reload_tape();
        base = wf_cnt[0];
        start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        @(negedge clk);
        check_int("exec_wf_before_reset", int'(wf_w[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        check_obs("reset_mid_exec", observe(0), mk(1'b0, 1'b0, 0, 1, 1, 0, 1'b0));
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_int("no_toggle_after_reset", wf_cnt[0] - base, 0);
        check_int("tape_untouched", int'(tape[0][1]), 0);
        check_obs("idle_after_reset", observe(0), mk(1'b0, 1'b0, 0, 1, 1, 0, 1'b0));

        // Same program from IDLE: toggle at 1, toggle at 0, then off the left edge
        run(0, 1'b0, wfd);
        check_obs("two_toggle_final", observe(0), mk(1'b0, 1'b1, 2, 0, 1, 2, 1'b0));
        check_int("two_toggle_count", wfd, 2);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
